room_fsm: RTL
=============

Name: room_fsm

Overview:
- Navigation state machine for the adventure game.
- Tracks the player's current room from N/S/E/W button inputs and raises sw while the player stands in the Secret Sword Stash.
- Sits directly upstream of the sword-tracking FSM: drives its sw input and consumes its v output to resolve the Dragon's Den encounter into win or die.
- Also drives room LEDs and a move counter for the display.

Parameters:
MOVE_W, 8, width of the saturating accepted-move counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; returns to Cave of Cacophony
n  input  1  north button, level, synchronous to clk
s  input  1  south button, level
e  input  1  east button, level
w  input  1  west button, level
v  input  1  vorpal sword held (from sword FSM)
sw  output  1  player is in Secret Sword Stash
win  output  1  player is in Victory Vault
die  output  1  player is in Grievous Graveyard
room  output  3  encoded current room (room_t)
room_led  output  7  one-hot current room, bit index = room_t value
moves  output  MOVE_W  count of accepted moves, saturating

Behaviour:
- Reset: clk and reset as already decided — reset reset, asynchronous, active-high; clock clk.
  - On reset: room = CAVE (0), room_led = 7'b0000001, sw = win = die = 0, moves = 0.
  - Direction history registers clear to 0.
  - Reset mid-game returns to CAVE immediately, regardless of state.
- Room encoding (room_t):
  - CAVE=0, TUNNEL=1, RIVER=2, STASH=3, DEN=4, VAULT=5, GRAVE=6.
  - Value 7 is illegal and recovers to CAVE on the next clock.
- Button edge detection:
  - Each of n/s/e/w is registered once per clock.
  - A press is the rising edge: current high and previous sample low.
  - Holding a button produces exactly one press.
- Move validity:
  - A move is a cycle with exactly one press.
  - Two or more simultaneous presses in the same cycle are ignored entirely; no transition, no count.
- Transitions (on a move; all other presses are ignored):
  - CAVE: e -> TUNNEL.
  - TUNNEL: w -> CAVE; s -> RIVER.
  - RIVER: n -> TUNNEL; w -> STASH; e -> DEN.
  - STASH: e -> RIVER.
  - DEN: no input needed. Next clock goes to VAULT if v = 1, else GRAVE. Presses in DEN are ignored.
  - VAULT, GRAVE: terminal; remain until reset.
- Latency:
  - Button rises at edge k (sampled) -> press detected in cycle k -> room updates at edge k+1.
  - DEN resolves one clock after entry, using v sampled at that edge.
- Outputs are Moore, decoded from the room register only:
  - sw = (room==STASH), win = (room==VAULT), die = (room==GRAVE).
  - room_led = 1 << room.
  - Exactly one of room_led is high at all times after reset.
- Sword-timing contract:
  - The sword FSM registers sw, so v rises one clock after STASH entry.
  - Leaving STASH needs a new press, which takes at least one more edge, so v is stable before DEN is reachable.
- moves counter:
  - Increments by 1 on every move that changes room. The automatic DEN resolution does not count.
  - Saturates at 2^MOVE_W-1.
  - Not incremented for ignored presses.

Decomposition:
- Package adventure_pkg holds:
  - room_t enum (3-bit) with the seven rooms above.
  - Constants ROOM_COUNT=7 and START_ROOM=CAVE, shared with the sword FSM bench and the display block.
- Sub-module btn_edge: 4-bit register plus rising-edge detect and a one-hot-valid flag. Outputs press[3:0] and move_valid.

Test Plan:
- Reset, then idle 5 clocks -> room=0, room_led=7'b0000001, sw=win=die=0, moves=0.
- Pulse e, s, w, each 1-cycle high with 1-cycle gaps -> room sequence 1, 2, 3; sw=1 in STASH; moves=3. Then pulse e, then e -> RIVER, then DEN; next clock VAULT with win=1 (bench sword FSM gives v=1); moves=5.
- From reset, pulse e, s, e -> DEN, then GRAVE on the next clock with v=0 -> die=1, win=0, sw never high. Further presses leave room=6 and moves=3.
- Hold e high for 10 cycles from CAVE -> exactly one move: room=1, moves=1.
- In RIVER, assert n and e in the same cycle -> room stays 2, moves unchanged. Then pulse e alone -> DEN.
- Assert reset asynchronously (between edges) while in STASH with moves=3 -> room=0, moves=0, sw=0 immediately, before the next clock edge. Force illegal room=7 via a bench-only injection -> CAVE after 1 clock.

Source files
------------

// File: rtl/adventure_pkg.sv
// Shared types for the adventure game: room encoding and button bit positions.
// Imported by the navigation FSM, the sword FSM bench and the display block.
package adventure_pkg;

  typedef enum logic [2:0] {
    CAVE   = 3'd0,
    TUNNEL = 3'd1,
    RIVER  = 3'd2,
    STASH  = 3'd3,
    DEN    = 3'd4,
    VAULT  = 3'd5,
    GRAVE  = 3'd6
  } room_t;

  localparam int    ROOM_COUNT = 7;
  localparam room_t START_ROOM = CAVE;

  // Bit positions inside the packed {n, s, e, w} button vector.
  localparam int BTN_N = 3;
  localparam int BTN_S = 2;
  localparam int BTN_E = 1;
  localparam int BTN_W = 0;

endpackage

// File: rtl/btn_edge.sv
// Registers the four direction buttons and flags rising edges.
// move_valid is high only when exactly one button produced a press this cycle.
module btn_edge (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [3:0] press,
  output logic       move_valid
);

  logic [3:0] cur_q;
  logic [3:0] prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q  <= 4'b0000;
      prev_q <= 4'b0000;
    end else begin
      cur_q  <= btn;
      prev_q <= cur_q;
    end
  end

  // A held button only registers once: it needs a low sample before the high one.
  assign press      = cur_q & ~prev_q;
  assign move_valid = $onehot(press);

endmodule

// File: rtl/room_fsm.sv
// Navigation FSM: tracks the player's room from button presses, resolves the
// Dragon's Den using the sword FSM's v input, and counts accepted moves.
module room_fsm
  import adventure_pkg::*;
#(
  parameter int MOVE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  n,
  input  logic                  s,
  input  logic                  e,
  input  logic                  w,
  input  logic                  v,
  output logic                  sw,
  output logic                  win,
  output logic                  die,
  output logic [2:0]            room,
  output logic [ROOM_COUNT-1:0] room_led,
  output logic [MOVE_W-1:0]     moves
);

  logic [3:0]        press;
  logic              move_valid;
  room_t             room_q;
  room_t             room_d;
  logic              step;
  logic [MOVE_W-1:0] moves_q;

  btn_edge u_btn_edge (
    .clk        (clk),
    .reset      (reset),
    .btn        ({n, s, e, w}),
    .press      (press),
    .move_valid (move_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      room_q  <= START_ROOM;
      moves_q <= '0;
    end else begin
      room_q <= room_d;
      if (step && (moves_q != {MOVE_W{1'b1}})) begin
        moves_q <= moves_q + 1'b1;
      end
    end
  end

  // step marks a player-initiated room change; the DEN resolution is not one.
  always_comb begin
    room_d = room_q;
    step   = 1'b0;
    case (room_q)
      CAVE: begin
        if (move_valid && press[BTN_E]) begin
          room_d = TUNNEL;
          step   = 1'b1;
        end
      end
      TUNNEL: begin
        if (move_valid && press[BTN_W]) begin
          room_d = CAVE;
          step   = 1'b1;
        end else if (move_valid && press[BTN_S]) begin
          room_d = RIVER;
          step   = 1'b1;
        end
      end
      RIVER: begin
        if (move_valid && press[BTN_N]) begin
          room_d = TUNNEL;
          step   = 1'b1;
        end else if (move_valid && press[BTN_W]) begin
          room_d = STASH;
          step   = 1'b1;
        end else if (move_valid && press[BTN_E]) begin
          room_d = DEN;
          step   = 1'b1;
        end
      end
      STASH: begin
        if (move_valid && press[BTN_E]) begin
          room_d = RIVER;
          step   = 1'b1;
        end
      end
      DEN:     room_d = v ? VAULT : GRAVE;
      VAULT:   room_d = VAULT;
      GRAVE:   room_d = GRAVE;
      default: room_d = START_ROOM;
    endcase
  end

  assign room     = room_q;
  assign sw       = (room_q == STASH);
  assign win      = (room_q == VAULT);
  assign die      = (room_q == GRAVE);
  assign room_led = {{(ROOM_COUNT-1){1'b0}}, 1'b1} << room_q;
  assign moves    = moves_q;

endmodule
